rtc_int_ctrl: RTL
=================

Name: rtc_int_ctrl

Overview:
- Multi-channel successor to the single-channel RTC interrupt clear control.
- Synchronises NUM_CH raw interrupt lines from the RTC clock domain into PCLK and applies a per-channel mask.
- Generates a per-channel held clear handshake back to the RTC domain; supervises each clear with a timeout.
- Sits between the APB register block (write strobes) and the RTC counter/match logic (raw interrupt sources).

Parameters:
- NUM_CH, 4: number of interrupt channels (1..16).
- SYNC_STAGES, 2: synchroniser depth for RawInt (2..3).
- CLR_TIMEOUT, 64: PCLK cycles IntClear may stay high before ClrTimeout is flagged (2..255).
- CNT_W, 8: width of per-channel event counters (optional feature only).

Ports:
- PCLK  input  1  APB clock.
- PRESETn  input  1  APB reset, asynchronous, active-low.
- RawInt  input  NUM_CH  raw interrupts, asynchronous to PCLK.
- IntClrWr  input  1  one-cycle write strobe to the interrupt clear register.
- IntClrData  input  NUM_CH  clear write data, one bit per channel.
- MaskWr  input  1  one-cycle write strobe to the mask register.
- MaskData  input  NUM_CH  mask write data; 1 = enabled.
- RawIntSync  output  NUM_CH  synchronised raw status (RIS).
- IntMask  output  NUM_CH  current mask register.
- MaskedInt  output  NUM_CH  masked status (MIS).
- RTCINTR  output  1  OR of MaskedInt.
- IntClear  output  NUM_CH  clear handshake to the RTC domain, registered.
- ClrTimeout  output  NUM_CH  sticky clear-timeout flags.
- IntCount  output  NUM_CH*CNT_W  per-channel event counters; channel n at bits [n*CNT_W +: CNT_W].

Behaviour:
- Reset, asynchronous: synchroniser flops, IntMask, IntClear, ClrTimeout, timers, IntCount and channel FSMs all go to 0/IDLE. Reset mid-clear aborts the clear immediately.
- RawIntSync: RawInt delayed through SYNC_STAGES PCLK flops. Latency is exactly SYNC_STAGES rising edges.
- IntMask: loaded from MaskData on the cycle MaskWr=1. A new mask is visible the cycle after the write.
- MaskedInt = RawIntSync & IntMask & ~IntClear. This is combinational, so MIS drops during an active clear. RTCINTR = |MaskedInt.
- Per-channel FSM, with independent channels:
  - IDLE (IntClear=0): if IntClrWr=1, IntClrData[n]=1 and RawIntSync[n]=1 in the same cycle -> CLEAR. IntClear[n]=1 from the next edge; timer loads 0. A clear write while RawIntSync[n]=0 is ignored, with no state change.
  - CLEAR (IntClear=1): timer increments each cycle, saturating at CLR_TIMEOUT.
    - When RawIntSync[n]=0 -> IDLE; IntClear[n]=0 from the next edge.
    - When the timer reaches CLR_TIMEOUT-1 while still in CLEAR, ClrTimeout[n] sets. The FSM stays in CLEAR with IntClear held.
    - Further clear writes in CLEAR are ignored.
- ClrTimeout[n] is cleared by a clear write with IntClrData[n]=1 accepted in any state. If the set and clear conditions coincide, set wins.
- Clear write and mask write in the same cycle: both take effect.
- RawIntSync[n] rising in the same cycle as the clear write: the current (pre-edge) RawIntSync value decides acceptance.
- Writes to bits of channels other than n never affect channel n.

Optional Feature:
- Macro RTC_INT_COUNT_EN.
- Defined: IntCount[n] increments on each rising edge of RawIntSync[n], detected against the previous registered RawIntSync. It saturates at 2^CNT_W-1 and is cleared to 0 by a clear write with IntClrData[n]=1, accepted or not. If a clear and an increment coincide, the result is 0.
- Undefined: IntCount is tied to 0 and no counter flops are built.

Test Plan:
- Reset with RawInt=4'hF -> all outputs 0. After release, RawIntSync=4'hF exactly 2 PCLK edges later; MaskedInt=0 and RTCINTR=0 while mask=0.
- MaskWr with 4'b0101, RawInt=4'hF -> MaskedInt=4'b0101 next cycle, RTCINTR=1. Clear write 4'b0001 -> IntClear=4'b0001 next cycle and MaskedInt=4'b0100. Drop RawInt[0] -> IntClear[0] falls 3 edges after the RawInt drop.
- Clear write 4'b0010 while RawIntSync[1]=0 -> IntClear stays 0. Raise RawInt[1] afterwards -> no clear occurs.
- RawInt[2] held high after an accepted clear, CLR_TIMEOUT=64 -> ClrTimeout[2]=1 at the 64th cycle of CLEAR, IntClear[2] stays 1. A clear write of 4'b0100 clears ClrTimeout[2].
- Assert PRESETn=0 mid-CLEAR on channel 3 -> IntClear[3] and the timer go to 0 asynchronously. After release, channel 3 is in IDLE.
- With RTC_INT_COUNT_EN and CNT_W=2, pulse RawInt[0] 5 times -> IntCount[1:0]=3 (saturated). A clear write of 4'b0001 -> 0.

Source files
------------

// File: rtl/rtc_int_ctrl.sv
// rtl/rtc_int_ctrl.sv - multi-channel RTC interrupt sync, mask and supervised clear handshake
// Optional per-channel event counters are built when RTC_INT_COUNT_EN is defined.
module rtc_int_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CLR_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [NUM_CH-1:0]       RawInt,
  input  logic                    IntClrWr,
  input  logic [NUM_CH-1:0]       IntClrData,
  input  logic                    MaskWr,
  input  logic [NUM_CH-1:0]       MaskData,
  output logic [NUM_CH-1:0]       RawIntSync,
  output logic [NUM_CH-1:0]       IntMask,
  output logic [NUM_CH-1:0]       MaskedInt,
  output logic                    RTCINTR,
  output logic [NUM_CH-1:0]       IntClear,
  output logic [NUM_CH-1:0]       ClrTimeout,
  output logic [NUM_CH*CNT_W-1:0] IntCount
);

  // Timer saturates at CLR_TIMEOUT; the flag is raised on the edge that
  // brings the timer to CLR_TIMEOUT-1, so it is visible alongside that value.
  localparam logic [7:0] TMO_SAT = 8'(CLR_TIMEOUT);
  localparam logic [7:0] TMO_PRE = 8'(CLR_TIMEOUT - 2);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } ch_state_e;

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] raw_sync;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] clr_hit;

  assign raw_sync = sync_q[SYNC_STAGES-1];
  assign clr_hit  = {NUM_CH{IntClrWr}} & IntClrData;

  // Synchroniser chain bringing the RTC-domain interrupt lines into PCLK.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= RawInt;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Mask register next-state: a write replaces the whole mask.
  always_comb begin
    mask_d = mask_q;
    if (MaskWr) mask_d = MaskData;
  end

  // Mask register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) mask_q <= '0;
    else          mask_q <= mask_d;
  end

  assign RawIntSync = raw_sync;
  assign IntMask    = mask_q;
  assign MaskedInt  = raw_sync & mask_q & ~IntClear;
  assign RTCINTR    = |MaskedInt;

`ifdef RTC_INT_COUNT_EN
  logic [NUM_CH-1:0] prev_q;
  logic [NUM_CH-1:0] rise;

  // Previous synchronised status, used only for rising-edge detection.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) prev_q <= '0;
    else          prev_q <= raw_sync;
  end

  assign rise = raw_sync & ~prev_q;
`endif

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    ch_state_e  state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       tmo_q, tmo_d;

    // Channel clear FSM: accept a clear only while the source is asserted,
    // hold IntClear until the source drops, flag a stuck source once.
    always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      tmo_d   = tmo_q;
      if (clr_hit[n]) tmo_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (clr_hit[n] && raw_sync[n]) begin
            state_d = CLEAR;
            timer_d = '0;
          end
        end
        CLEAR: begin
          if (!raw_sync[n]) begin
            state_d = IDLE;
            timer_d = '0;
          end else begin
            if (timer_q != TMO_SAT) timer_d = timer_q + 8'd1;
            if (timer_q == TMO_PRE) tmo_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Channel state, timer and sticky timeout flag; reset aborts any clear.
    always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
        state_q <= IDLE;
        timer_q <= '0;
        tmo_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        timer_q <= timer_d;
        tmo_q   <= tmo_d;
      end
    end

    assign IntClear[n]   = (state_q == CLEAR);
    assign ClrTimeout[n] = tmo_q;

`ifdef RTC_INT_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Event counter: saturating, cleared by any clear write to this channel.
    always_comb begin
      cnt_d = cnt_q;
      if (clr_hit[n])                    cnt_d = '0;
      else if (rise[n] && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    // Event counter register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) cnt_q <= '0;
      else          cnt_q <= cnt_d;
    end

    assign IntCount[n*CNT_W +: CNT_W] = cnt_q;
`else
    assign IntCount[n*CNT_W +: CNT_W] = '0;
`endif
  end

endmodule
